ps2_kbd_receiver: RTL and testbench
===================================

// Module: ps2_kbd_receiver
// PURPOSE
//   PS/2 keyboard front end feeding the CPU's keyboard MMIO port (kbd_ready/kbd_data/kbd_overflow).
//   - Deserialises 11-bit device-to-host PS/2 frames into bytes.
//   - Buffers the bytes in a small show-ahead FIFO.
//   - Pops one byte per CPU kbd_read_enable pulse.
//   - Sits between the board PS/2 pins and the single-cycle CPU top.
// PARAMETERS
//   FIFO_DEPTH      8      byte entries; power of 2, >= 2
//   TIMEOUT_CYCLES  50000  clk cycles without a PS/2 falling edge before a partial frame is abandoned
// PORTS
//   clk          in   1  system clock (same clock as the CPU)
//   rst          in   1  asynchronous, active-low reset
//   ps2_clk      in   1  raw PS/2 clock pin (asynchronous)
//   ps2_data     in   1  raw PS/2 data pin (asynchronous)
//   read_enable  in   1  pop request from CPU (kbd_read_enable)
//   data         out  8  FIFO head byte (kbd_data)
//   ready        out  1  FIFO non-empty (kbd_ready)
//   overflow     out  1  sticky: a byte was dropped because the FIFO was full (kbd_overflow)
// BEHAVIOUR
//   Reset
//     - rst low: FSM=IDLE, bit/timeout counters=0, FIFO pointers=0.
//     - data=8'h00, ready=0, overflow=0, sync flops=1.
//     - Reset asserted mid-frame discards the partial frame and all buffered bytes.
//   Synchronisation
//     - ps2_clk/ps2_data each pass through 2 sync flops.
//     - A third flop on clk detects falling edges: fall = prev & ~sync.
//     - Data is sampled on the cycle fall=1.
//   Frame FSM (advances only on fall, except timeout)
//     - IDLE:   data=0 -> DATA, bit_cnt=0. Data=1 is a bad start bit: stay in IDLE.
//     - DATA:   shift in LSB first; after the 8th bit -> PARITY.
//     - PARITY: latch parity bit -> STOP.
//     - STOP:   if stop=1 and the frame is valid, push the byte. Return to IDLE in every case.
//     - Timeout counter runs in any state != IDLE and clears on every fall.
//     - Counter reaching TIMEOUT_CYCLES -> IDLE, frame discarded, no push.
//   Latency
//     - ready rises after exactly 3 rising clk edges following the stop-bit falling edge on ps2_clk
//       (2 sync + push), when the FIFO was empty.
//   FIFO (show-ahead)
//     - data = head entry whenever ready=1; data=8'h00 when empty.
//     - Pop on a clk edge where read_enable=1 and ready=1.
//     - read_enable while empty is ignored with no side effects.
//     - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//     - count is log2(FIFO_DEPTH)+1 bits.
//   Full / overflow
//     - Push while full and no pop: byte dropped, overflow<=1, FIFO contents unchanged.
//     - Simultaneous push and pop while full: both happen, count unchanged, no overflow.
//     - Simultaneous push and pop while empty: pop ignored, push happens, ready=1 next cycle.
//     - overflow clears on the next accepted pop. If that pop coincides with a dropping push,
//       overflow stays 1 (set wins).
// CONFIGURATION
//   PS2_PARITY_CHECK_EN
//     - Defined: frame is valid only if the 8 data bits plus the parity bit hold an odd number of 1s.
//       Parity-failed frames are discarded silently.
//     - Undefined: parity bit is sampled but ignored; only the start and stop bits qualify a frame.
// TESTING
//   1. Frame 0x1C (start 0, LSB-first, parity 0, stop 1), ps2_clk period 100 clk
//      -> ready=1 3 edges after last fall, data=8'h1C; one read_enable pulse -> ready=0.
//   2. Send 8 bytes 0x01..0x08 with no reads, then a 9th byte 0x09
//      -> overflow=1, data=8'h01; 8 pops return 01..08; overflow clears on the 1st pop.
//   3. Frame 0x1C with parity bit 1
//      -> PS2_PARITY_CHECK_EN defined: ready stays 0; undefined: data=8'h1C.
//   4. Send 4 clock edges, then stall ps2_clk high for TIMEOUT_CYCLES
//      -> FSM=IDLE, no push; a following full 0xF0 frame is received correctly.
//   5. FIFO full, stop-bit edge on the same cycle as read_enable
//      -> no overflow, count stays 8, new byte lands at tail.
//   6. rst low mid-frame with 3 bytes buffered
//      -> ready=0, data=0, overflow=0 immediately (asynchronous); the next frame is received cleanly.

Source files
------------

// File: rtl/ps2_kbd_receiver_if.sv
// CPU-side keyboard MMIO bundle: pop request in, head byte / status out.
interface ps2_kbd_receiver_if;
  logic       read_enable;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  // CPU side drives the pop request and observes the FIFO head
  modport master (output read_enable, input data, input ready, input overflow);
  // Receiver side serves the FIFO head and status flags
  modport slave  (input read_enable, output data, output ready, output overflow);
endinterface

// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deframes 11-bit
// device-to-host frames and buffers the bytes in a show-ahead FIFO that the
// CPU pops one byte at a time.
// Optional build macro: PS2_PARITY_CHECK_EN (enables odd-parity qualification
// of frames; when undefined only start/stop bits qualify a frame).
module ps2_kbd_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_kbd_receiver_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity over data bits plus parity bit: 1 when the count of ones is odd
  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction
`endif

  logic [1:0]       clk_sync_r, data_sync_r;
  logic             clk_prev_r;
  logic             fall_s, din_s;
  state_t           state_r, state_next_s;
  logic [2:0]       bit_cnt_r, bit_cnt_next_s;
  logic [7:0]       shift_r, shift_next_s;
  logic [TO_W-1:0]  tcnt_r;
  logic             timeout_s, frame_ok_s, push_s;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_next_s;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic             full_s, pop_s, wr_en_s, drop_s;
  logic             ready_r, overflow_r;
  logic [7:0]       data_r, head_next_s;

  assign fall_s    = clk_prev_r & ~clk_sync_r[1];
  assign din_s     = data_sync_r[1];
  assign timeout_s = (tcnt_r == TO_W'(TIMEOUT_CYCLES));

  // Two-flop synchronisers for both pins plus the edge-detect history flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_r;
  // Capture the parity bit so the stop-bit cycle can qualify the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_r <= 1'b0;
    end else if (fall_s && (state_r == PARITY)) begin
      parity_r <= din_s;
    end else begin
      parity_r <= parity_r;
    end
  end
  assign frame_ok_s = odd_parity({parity_r, shift_r});
`else
  assign frame_ok_s = 1'b1;
`endif

  // Frame FSM next state: steps on PS/2 falling edges, abandons on timeout
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    push_s         = 1'b0;
    if (fall_s) begin
      case (state_r)
        IDLE: begin
          if (!din_s) begin
            state_next_s   = DATA;
            bit_cnt_next_s = 3'd0;
          end else begin
            state_next_s   = IDLE;
          end
        end
        DATA: begin
          shift_next_s   = {din_s, shift_r[7:1]};
          bit_cnt_next_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_next_s = PARITY;
          end else begin
            state_next_s = DATA;
          end
        end
        PARITY: state_next_s = STOP;
        STOP: begin
          push_s       = din_s & frame_ok_s;
          state_next_s = IDLE;
        end
        default: state_next_s = IDLE;
      endcase
    end else if (timeout_s) begin
      state_next_s = IDLE;
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame FSM state, bit counter and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      shift_r   <= shift_next_s;
    end
  end

  // Inactivity counter: idles at zero, restarts on every PS/2 falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_r <= {TO_W{1'b0}};
    end else if ((state_r == IDLE) || fall_s || timeout_s) begin
      tcnt_r <= {TO_W{1'b0}};
    end else begin
      tcnt_r <= tcnt_r + TO_W'(1'b1);
    end
  end

  // FIFO control: a pop frees a slot in the same cycle, so push+pop when full is accepted
  always_comb begin
    full_s        = (count_r == CNT_W'(FIFO_DEPTH));
    pop_s         = bus.read_enable & ready_r;
    wr_en_s       = push_s & (~full_s | pop_s);
    drop_s        = push_s & full_s & ~pop_s;
    rd_ptr_next_s = pop_s ? (rd_ptr_r + PTR_W'(1'b1)) : rd_ptr_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1'b1);
      2'b01:   count_next_s = count_r - CNT_W'(1'b1);
      default: count_next_s = count_r;
    endcase
    // The incoming byte becomes the head when it lands in the slot being exposed
    if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = shift_r;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // FIFO storage, pointers and registered CPU-facing outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      ready_r    <= 1'b0;
      data_r     <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      ready_r  <= (count_next_s != {CNT_W{1'b0}});
      data_r   <= (count_next_s != {CNT_W{1'b0}}) ? head_next_s : 8'h00;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (pop_s) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign bus.ready    = ready_r;
  assign bus.data     = data_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// Self-checking bench for ps2_kbd_receiver: drives PS/2 frames on the pins,
// keeps a byte scoreboard and pops/compares through the CPU interface.
module tb_ps2_kbd_receiver;
  localparam int TO_CYC = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_b;

  ps2_kbd_receiver_if kbd ();

  ps2_kbd_receiver #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(kbd)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    wait_clk(1);
    ps2_data = b;
    wait_clk(50);
    ps2_clk = 1'b0;
    wait_clk(50);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stp);
  endtask

  // Sends everything up to and including the stop-bit falling edge, then returns
  task automatic frame_to_stop(input logic [7:0] b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b);
    wait_clk(1);
    ps2_data = 1'b1;
    wait_clk(50);
    ps2_clk = 1'b0;
  endtask

  task automatic good_frame(input logic [7:0] b, input logic expect_push);
    send_frame(b, ~^b, 1'b1);
    if (expect_push) sb.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    int w;
    w = 0;
    @(posedge clk); #1;
    while (!kbd.ready && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!kbd.ready) begin
      check_eq({tag, "_wait"}, {31'd0, kbd.ready}, 32'd1);
    end else begin
      exp_b = sb.pop_front();
      check_eq(tag, {24'd0, kbd.data}, {24'd0, exp_b});
      kbd.read_enable = 1'b1;
      wait_clk(1);
      kbd.read_enable = 1'b0;
    end
  endtask

  initial begin
    kbd.read_enable = 1'b0;
    wait_clk(3);
    check_eq("rst_ready", {31'd0, kbd.ready}, 32'd0);
    check_eq("rst_data", {24'd0, kbd.data}, 32'h00);
    check_eq("rst_ovf", {31'd0, kbd.overflow}, 32'd0);
    rst = 1'b1;
    wait_clk(5);

    // 1: latency of a single frame
    frame_to_stop(8'h1C);
    wait_clk(2);
    check_eq("t1_ready_edge2", {31'd0, kbd.ready}, 32'd0);
    wait_clk(1);
    check_eq("t1_ready_edge3", {31'd0, kbd.ready}, 32'd1);
    check_eq("t1_data", {24'd0, kbd.data}, 32'h1C);
    wait_clk(47);
    ps2_clk = 1'b1;
    sb.push_back(8'h1C);
    pop_check("t1_pop");
    check_eq("t1_empty", {31'd0, kbd.ready}, 32'd0);
    check_eq("t1_empty_data", {24'd0, kbd.data}, 32'h00);

    // 2: fill, overflow on the ninth byte, drain
    for (int i = 1; i <= 8; i++) good_frame(8'(i), 1'b1);
    check_eq("t2_no_ovf_full", {31'd0, kbd.overflow}, 32'd0);
    good_frame(8'h09, 1'b0);
    check_eq("t2_ovf", {31'd0, kbd.overflow}, 32'd1);
    check_eq("t2_head", {24'd0, kbd.data}, 32'h01);
    pop_check("t2_pop0");
    check_eq("t2_ovf_clear", {31'd0, kbd.overflow}, 32'd0);
    for (int i = 1; i < 8; i++) pop_check("t2_pop");
    check_eq("t2_empty", {31'd0, kbd.ready}, 32'd0);

    // 3: bad parity
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    wait_clk(5);
    check_eq("t3_par_drop", {31'd0, kbd.ready}, 32'd0);
`else
    sb.push_back(8'h1C);
    pop_check("t3_par_ignored");
`endif

    // bad stop bit is never pushed
    send_frame(8'hA5, ~^8'hA5, 1'b0);
    wait_clk(5);
    check_eq("stop_bad", {31'd0, kbd.ready}, 32'd0);

    // 4: partial frame abandoned after the timeout
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_clk(TO_CYC + 100);
    check_eq("t4_no_push", {31'd0, kbd.ready}, 32'd0);
    good_frame(8'hF0, 1'b1);
    pop_check("t4_after_to");

    // 5: push and pop on the same edge while full
    for (int i = 0; i < 8; i++) good_frame(8'h10 + 8'(i), 1'b1);
    frame_to_stop(8'h5A);
    wait_clk(2);
    exp_b = sb.pop_front();
    check_eq("t5_head", {24'd0, kbd.data}, {24'd0, exp_b});
    kbd.read_enable = 1'b1;
    wait_clk(1);
    kbd.read_enable = 1'b0;
    sb.push_back(8'h5A);
    check_eq("t5_no_ovf", {31'd0, kbd.overflow}, 32'd0);
    check_eq("t5_ready", {31'd0, kbd.ready}, 32'd1);
    check_eq("t5_new_head", {24'd0, kbd.data}, {24'd0, sb[0]});
    wait_clk(47);
    ps2_clk = 1'b1;
    good_frame(8'h77, 1'b0);
    check_eq("t5_still_full", {31'd0, kbd.overflow}, 32'd1);
    for (int i = 0; i < 8; i++) pop_check("t5_drain");
    check_eq("t5_empty", {31'd0, kbd.ready}, 32'd0);

    // random bytes through the scoreboard
    for (int i = 0; i < 4; i++) good_frame(8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 4; i++) pop_check("rand_pop");

    // 6: reset mid-frame with bytes buffered
    for (int i = 0; i < 3; i++) good_frame(8'h40 + 8'(i), 1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    check_eq("t6_buffered", {31'd0, kbd.ready}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("t6_rst_ready", {31'd0, kbd.ready}, 32'd0);
    check_eq("t6_rst_data", {24'd0, kbd.data}, 32'h00);
    check_eq("t6_rst_ovf", {31'd0, kbd.overflow}, 32'd0);
    sb.delete();
    wait_clk(5);
    rst = 1'b1;
    wait_clk(5);
    good_frame(8'h3C, 1'b1);
    pop_check("t6_after_rst");
    check_eq("t6_empty", {31'd0, kbd.ready}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
